// File: rtl/data_read_capture.sv
// Capture front end: packs 8-bit DIN samples into little-endian 32-bit words
// and queues them in a first-word-fall-through FIFO for the AXI read slave.
module data_read_capture #(
   parameter int FIFO_AW = 9
) (
   input  logic                S_AXI_ACLK,
   input  logic                S_AXI_ARESET,
   input  logic [7:0]          DIN,
   input  logic                DIN_VALID,
   input  logic                START,
   input  logic                STOP,
   input  logic                CLR,
   input  logic [31:0]         SAMPLE_LIMIT,
   input  logic                FIFO_RD,
   output logic [31:0]         FIFO_DATA,
   output logic                FIFO_EMPTY,
   output logic [FIFO_AW:0]    FIFO_COUNT,
   output logic                BUSY,
   output logic                DONE,
   output logic                OVERFLOW
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_FLUSH   = 2'd2;

   localparam logic [FIFO_AW:0] FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};

   // capture side
   logic [1:0]  state_reg;
   logic [31:0] limit_reg;
   logic [31:0] sample_cnt_reg;
   logic [31:0] sample_cnt_inc;
   logic [31:0] pack_reg;
   logic [31:0] pack_fill;
   logic [1:0]  idx_reg;
   logic        stop_hit_reg;
   logic        push_pending_reg;
   logic [31:0] push_word_reg;
   logic        done_reg;
   logic        accept;
   logic        limit_hit;

   // FIFO side
   logic [31:0]        ram_mem [(1 << FIFO_AW)];
   logic [FIFO_AW-1:0] wr_ptr_reg;
   logic [FIFO_AW-1:0] rd_ptr_reg;
   logic [FIFO_AW-1:0] rd_ptr_next;
   logic [FIFO_AW:0]   count_reg;
   logic [FIFO_AW:0]   count_next;
   logic [31:0]        head_reg;
   logic               overflow_reg;
   logic               flush_push;
   logic               push_req;
   logic [31:0]        push_data;
   logic               fifo_full;
   logic               pop;
   logic               push;
   logic               drop;
   logic               head_bypass;

   // A sample is taken only while capturing and before a stop/limit has been seen.
   assign accept         = (state_reg == ST_CAPTURE) && !stop_hit_reg && DIN_VALID;
   assign sample_cnt_inc = sample_cnt_reg + 32'd1;
   assign limit_hit      = (limit_reg != 32'd0) && (sample_cnt_inc == limit_reg);

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign pack_fill[8*gi +: 8] = (idx_reg == 2'(gi)) ? DIN : pack_reg[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET || CLR) begin
         state_reg        <= ST_IDLE;
         limit_reg        <= 32'd0;
         sample_cnt_reg   <= 32'd0;
         pack_reg         <= 32'd0;
         idx_reg          <= 2'd0;
         stop_hit_reg     <= 1'b0;
         push_pending_reg <= 1'b0;
         push_word_reg    <= 32'd0;
         done_reg         <= 1'b0;
      end else begin
         push_pending_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (START) begin
                  state_reg      <= ST_CAPTURE;
                  limit_reg      <= SAMPLE_LIMIT;
                  sample_cnt_reg <= 32'd0;
                  pack_reg       <= 32'd0;
                  idx_reg        <= 2'd0;
                  stop_hit_reg   <= 1'b0;
                  done_reg       <= 1'b0;
               end
            end
            ST_CAPTURE: begin
               if (stop_hit_reg) begin
                  state_reg <= ST_FLUSH;
               end else if (accept) begin
                  sample_cnt_reg <= sample_cnt_inc;
                  idx_reg        <= idx_reg + 2'd1;
                  // Completed words leave via a one-word stage; the pack register
                  // restarts from zero so a later partial word is already padded.
                  if (idx_reg == 2'd3) begin
                     push_word_reg    <= pack_fill;
                     push_pending_reg <= 1'b1;
                     pack_reg         <= 32'd0;
                  end else begin
                     pack_reg <= pack_fill;
                  end
                  if (STOP || limit_hit) begin
                     stop_hit_reg <= 1'b1;
                  end
               end else if (STOP) begin
                  stop_hit_reg <= 1'b1;
               end
            end
            ST_FLUSH: begin
               state_reg    <= ST_IDLE;
               done_reg     <= 1'b1;
               pack_reg     <= 32'd0;
               idx_reg      <= 2'd0;
               stop_hit_reg <= 1'b0;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // The partial word is written straight from the pack register on the flush edge.
   assign flush_push  = (state_reg == ST_FLUSH) && (idx_reg != 2'd0);
   assign push_req    = push_pending_reg || flush_push;
   assign push_data   = push_pending_reg ? push_word_reg : pack_reg;

   assign fifo_full   = (count_reg == FULL_COUNT);
   assign pop         = FIFO_RD && (count_reg != '0);
   assign push        = push_req && (!fifo_full || pop);
   assign drop        = push_req && fifo_full && !pop;
   assign rd_ptr_next = rd_ptr_reg + FIFO_AW'(pop);
   assign count_next  = count_reg + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
   // The word being written lands in the head slot when the FIFO is (or becomes) empty.
   assign head_bypass = push && (wr_ptr_reg == rd_ptr_next);

   always_ff @(posedge S_AXI_ACLK) begin
      if (push) begin
         ram_mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET || CLR) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         head_reg     <= 32'd0;
         overflow_reg <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
         end
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         if (drop) begin
            overflow_reg <= 1'b1;
         end
         if (count_next == '0) begin
            head_reg <= 32'd0;
         end else if (head_bypass) begin
            head_reg <= push_data;
         end else begin
            head_reg <= ram_mem[rd_ptr_next];
         end
      end
   end

   assign FIFO_DATA  = head_reg;
   assign FIFO_EMPTY = (count_reg == '0);
   assign FIFO_COUNT = count_reg;
   assign BUSY       = (state_reg != ST_IDLE);
   assign DONE       = done_reg;
   assign OVERFLOW   = overflow_reg;

endmodule
